// File: rtl/riscv_types.sv
// Shared types for the RV32 core pipeline sequencing logic.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package riscv_types;

    // Hazard controller sequencing state.
    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

    // One bus carrying every pipeline register enable and clear.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_exe_en;
        logic exe_mem_en;
        logic mem_wb_en;
        logic if_id_clr;
        logic id_exe_clr;
        logic exe_mem_clr;
        logic mem_wb_clr;
    } pipe_ctrl_t;

    // Architectural zero register; never a true dependency.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Normal flow: everything advances, nothing cleared.
    localparam pipe_ctrl_t PIPE_RUN = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_exe_en: 1'b1, exe_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_clr: 1'b0, id_exe_clr: 1'b0, exe_mem_clr: 1'b0, mem_wb_clr: 1'b0
    };

    // Reset: keep clocking so every stage fills with bubbles.
    localparam pipe_ctrl_t PIPE_RESET = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_exe_en: 1'b1, exe_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_clr: 1'b1, id_exe_clr: 1'b1, exe_mem_clr: 1'b1, mem_wb_clr: 1'b1
    };

    // Memory wait: freeze PC..EXE/MEM, push a bubble into WB.
    localparam pipe_ctrl_t PIPE_MEM_WAIT = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_exe_en: 1'b0, exe_mem_en: 1'b0, mem_wb_en: 1'b1,
        if_id_clr: 1'b0, id_exe_clr: 1'b0, exe_mem_clr: 1'b0, mem_wb_clr: 1'b1
    };

    // Taken branch/jump: squash the three younger instructions.
    localparam pipe_ctrl_t PIPE_FLUSH = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_exe_en: 1'b1, exe_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_clr: 1'b1, id_exe_clr: 1'b1, exe_mem_clr: 1'b1, mem_wb_clr: 1'b0
    };

    // Load-use: hold PC and IF/ID, insert one bubble into EXE.
    localparam pipe_ctrl_t PIPE_LOAD_USE = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_exe_en: 1'b1, exe_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_clr: 1'b0, id_exe_clr: 1'b1, exe_mem_clr: 1'b0, mem_wb_clr: 1'b0
    };

    // True when a source operand is actually read and names the given register.
    function automatic logic reg_match(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Latency: count reflects an increment one cycle after inc.
// Backpressure: none; synchronous active-high reset clears to zero.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Increment on request unless already at the maximum value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: stage enables/clears from load-use, MEM-resolved branches and dmem waits.
// Latency: enables/clears combinational (same cycle); bus_err, counters and FSM registered.
// Backpressure: dmem_ready low freezes PC..EXE/MEM; watchdog forces release after MAX_WAIT cycles.
module pipeline_hazard_ctrl
    import riscv_types::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             uses_rs1_id,
    input  logic             uses_rs2_id,
    input  logic [4:0]       rd_exe,
    input  logic             mem_to_reg_exe,
    input  logic             pc_sel_mem,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             pc_reg_en,
    output logic             if_id_reg_en,
    output logic             id_exe_reg_en,
    output logic             exe_mem_reg_en,
    output logic             mem_wb_reg_en,
    output logic             if_id_reg_clr,
    output logic             id_exe_reg_clr,
    output logic             exe_mem_reg_clr,
    output logic             mem_wb_reg_clr,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wide enough to hold MAX_WAIT itself.
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    // Counter value on the last permitted wait cycle; the watchdog fires here.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    hz_state_t         state;
    hz_state_t         state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              bus_err_nxt;

    logic              timeout;
    logic              mem_wait;
    logic              load_use;
    logic              flush_apply;
    logic              stall_inc;
    pipe_ctrl_t        ctrl;

    // Watchdog: on the last permitted cycle the access is treated as complete.
    assign timeout  = (state == HZ_MEM_WAIT) && (wait_cnt == WAIT_LAST);
    assign mem_wait = dmem_req_mem && !dmem_ready && !timeout;

    // A load in EXE whose result the ID instruction needs; x0 is never a dependency.
    assign load_use = mem_to_reg_exe && (rd_exe != REG_X0) &&
                      (reg_match(uses_rs1_id, rs1_id, rd_exe) ||
                       reg_match(uses_rs2_id, rs2_id, rd_exe));

    // Select the pipeline control pattern; mem_wait outranks flush, flush outranks load-use.
    always_comb begin
        ctrl = PIPE_RUN;
        if (reset) begin
            ctrl = PIPE_RESET;
        end else if (mem_wait) begin
            // Frozen stages hold any pending branch or load-use until release.
            ctrl = PIPE_MEM_WAIT;
        end else if (pc_sel_mem) begin
            // The hazarding instructions are being squashed, so load-use is moot.
            ctrl = PIPE_FLUSH;
        end else if (load_use) begin
            ctrl = PIPE_LOAD_USE;
        end
    end

    assign pc_reg_en       = ctrl.pc_en;
    assign if_id_reg_en    = ctrl.if_id_en;
    assign id_exe_reg_en   = ctrl.id_exe_en;
    assign exe_mem_reg_en  = ctrl.exe_mem_en;
    assign mem_wb_reg_en   = ctrl.mem_wb_en;
    assign if_id_reg_clr   = ctrl.if_id_clr;
    assign id_exe_reg_clr  = ctrl.id_exe_clr;
    assign exe_mem_reg_clr = ctrl.exe_mem_clr;
    assign mem_wb_reg_clr  = ctrl.mem_wb_clr;

    // Memory-wait FSM next state: track wait length, flag a bus error on watchdog release.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        bus_err_nxt  = 1'b0;
        case (state)
            HZ_RUN: begin
                // Ready in the entry cycle never reaches here: mem_wait is already low.
                if (mem_wait) begin
                    state_nxt    = HZ_MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            HZ_MEM_WAIT: begin
                if (mem_wait) begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end else begin
                    state_nxt    = HZ_RUN;
                    wait_cnt_nxt = '0;
                    // Only a forced release is an error; real ready on the last cycle is fine.
                    bus_err_nxt  = timeout && dmem_req_mem && !dmem_ready;
                end
            end
            default: begin
                state_nxt    = HZ_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state, wait counter and one-cycle bus error pulse; reset aborts any wait silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HZ_RUN;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            bus_err  <= bus_err_nxt;
        end
    end

    // A flush counts only when it actually takes effect, i.e. not deferred by a wait.
    assign flush_apply = !reset && pc_sel_mem && !mem_wait;
    assign stall_inc   = !reset && !ctrl.pc_en;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_apply),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a queue-based scoreboard.
// Stimulus drives #1 after posedge and queues the expected response; monitor compares at negedge.
// Narrow counters make saturation reachable within the watchdog sequence.
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 16;
    localparam int CW       = 4;

    // Control vector order: pc, if_id, id_exe, exe_mem, mem_wb enables, then if_id..mem_wb clears.
    localparam logic [8:0] C_RUN = 9'b11111_0000;
    localparam logic [8:0] C_RST = 9'b11111_1111;
    localparam logic [8:0] C_LU  = 9'b00111_0100;
    localparam logic [8:0] C_FL  = 9'b11111_1110;
    localparam logic [8:0] C_MW  = 9'b00001_0001;

    logic          clk;
    logic          reset;
    logic [4:0]    rs1_id, rs2_id, rd_exe;
    logic          uses_rs1_id, uses_rs2_id, mem_to_reg_exe;
    logic          pc_sel_mem, dmem_req_mem, dmem_ready;
    logic          pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en;
    logic          if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr;
    logic          bus_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct {
        logic [8:0]    ctrl;
        logic          berr;
        logic [CW-1:0] st;
        logic [CW-1:0] fl;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [8:0] act_ctrl;
    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .uses_rs1_id     (uses_rs1_id),
        .uses_rs2_id     (uses_rs2_id),
        .rd_exe          (rd_exe),
        .mem_to_reg_exe  (mem_to_reg_exe),
        .pc_sel_mem      (pc_sel_mem),
        .dmem_req_mem    (dmem_req_mem),
        .dmem_ready      (dmem_ready),
        .pc_reg_en       (pc_reg_en),
        .if_id_reg_en    (if_id_reg_en),
        .id_exe_reg_en   (id_exe_reg_en),
        .exe_mem_reg_en  (exe_mem_reg_en),
        .mem_wb_reg_en   (mem_wb_reg_en),
        .if_id_reg_clr   (if_id_reg_clr),
        .id_exe_reg_clr  (id_exe_reg_clr),
        .exe_mem_reg_clr (exe_mem_reg_clr),
        .mem_wb_reg_clr  (mem_wb_reg_clr),
        .bus_err         (bus_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected counter value after clamping at the counter's maximum.
    function automatic logic [CW-1:0] satv(input int v);
        int mx;
        mx = (1 << CW) - 1;
        return (v > mx) ? CW'(mx) : CW'(v);
    endfunction

    // Apply one cycle of inputs and queue the hand-computed response.
    // Counter/bus_err expectations are the registered values seen during this cycle.
    task automatic cyc(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic ld, input logic psel,
                       input logic dreq, input logic drdy, input logic rst,
                       input logic [8:0] ectrl, input logic eberr, input int est, input int efl,
                       input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rs1_id         = rs1;
        uses_rs1_id    = u1;
        rs2_id         = rs2;
        uses_rs2_id    = u2;
        rd_exe         = rd;
        mem_to_reg_exe = ld;
        pc_sel_mem     = psel;
        dmem_req_mem   = dreq;
        dmem_ready     = drdy;
        reset          = rst;
        e.ctrl = ectrl;
        e.berr = eberr;
        e.st   = satv(est);
        e.fl   = satv(efl);
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: pop one expected entry per cycle and compare every output group.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            act_ctrl = {pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en,
                        if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr};
            checks++;
            if (act_ctrl !== mon_e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl got=%b want=%b", mon_e.name, act_ctrl, mon_e.ctrl);
            end
            checks++;
            if (bus_err !== mon_e.berr) begin
                errors++;
                $display("FAIL %s bus_err got=%b want=%b", mon_e.name, bus_err, mon_e.berr);
            end
            checks++;
            if (stall_cnt !== mon_e.st) begin
                errors++;
                $display("FAIL %s stall_cnt got=%0d want=%0d", mon_e.name, stall_cnt, mon_e.st);
            end
            checks++;
            if (flush_cnt !== mon_e.fl) begin
                errors++;
                $display("FAIL %s flush_cnt got=%0d want=%0d", mon_e.name, flush_cnt, mon_e.fl);
            end
        end
    end

    initial begin
        reset = 1'b1;
        rs1_id = '0; rs2_id = '0; rd_exe = '0;
        uses_rs1_id = 1'b0; uses_rs2_id = 1'b0; mem_to_reg_exe = 1'b0;
        pc_sel_mem = 1'b0; dmem_req_mem = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);

        //   rs1 u1  rs2 u2  rd ld  psel dreq drdy rst  ctrl   be st fl
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RST, 0, 0, 0, "reset");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0, "idle");
        // Load-use on rs1, then the bubble has moved on.
        cyc(5, 1, 0, 0, 5, 1, 0, 0, 0, 0, C_LU,  0, 0, 0, "lu_rs1");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 1, 0, "lu_after");
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, C_RUN, 0, 1, 0, "lu_x0");
        cyc(3, 1, 7, 1, 7, 1, 0, 0, 0, 0, C_LU,  0, 1, 0, "lu_rs2");
        cyc(0, 0, 7, 0, 7, 1, 0, 0, 0, 0, C_RUN, 0, 2, 0, "lu_rs2_unused");
        cyc(7, 1, 0, 0, 7, 0, 0, 0, 0, 0, C_RUN, 0, 2, 0, "no_load");
        // Taken branch, alone and together with a load-use.
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_FL,  0, 2, 0, "flush");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 2, 1, "flush_after");
        cyc(5, 1, 0, 0, 5, 1, 1, 0, 0, 0, C_FL,  0, 2, 1, "flush_lu");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 2, 2, "flush_lu_after");
        // Three-cycle memory wait, then release.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MW,  0, 2, 2, "mw1");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MW,  0, 3, 2, "mw2");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MW,  0, 4, 2, "mw3");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_RUN, 0, 5, 2, "mw_release");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 5, 2, "mw_after");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_RUN, 0, 5, 2, "mw_zero_wait");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 5, 2, "mw_zero_after");
        // Branch held during a two-cycle wait; flush lands on the ready cycle.
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, C_MW,  0, 5, 2, "comb_w1");
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, C_MW,  0, 6, 2, "comb_w2");
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, C_FL,  0, 7, 2, "comb_release");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 7, 3, "comb_after");
        // Watchdog: 15 frozen cycles, forced release on the 16th; stall_cnt saturates.
        for (int i = 0; i < MAX_WAIT - 1; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MW, 0, 7 + i, 3, "wd_wait");
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RUN, 0, 22, 3, "wd_release");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 1, 22, 3, "wd_bus_err");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_RUN, 0, 22, 3, "wd_err_once");
        // Reset while in MEM_WAIT aborts the wait with no bus error.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MW,  0, 22, 3, "rw_enter");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MW,  0, 22, 3, "rw_wait");
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, C_RST, 0, 22, 3, "rw_reset");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_RST, 0, 0, 0, "rw_reset_hold");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MW,  0, 0, 0, "rw_new_wait");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_RUN, 0, 1, 0, "rw_release");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 1, 0, "rw_no_bus_err");

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
